fft_peak_scan_ctrl: RTL
=======================

Name: fft_peak_scan_ctrl

Overview:
- Read-out sequencer for the FFT magnitude ROM: on `start`, scans bins 0..NUM_BINS-1 through the ROM's synchronous read port.
- Streams each magnitude downstream on a valid/ready interface with full backpressure support.
- Tracks the peak magnitude and its bin index during the scan.
- Sits between the magnitude ROM and the display/UART export path.

Parameters:
- DATA_WIDTH, 26, magnitude word width; must equal the ROM width.
- ADDR_WIDTH, 13, ROM address width.
- NUM_BINS, 8192, bins per scan; legal range 2 to 2**ADDR_WIDTH.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle scan request; sampled only in IDLE.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the final bin is accepted downstream.
- rom_addr  out  ADDR_WIDTH  ROM read address.
- rom_data  in  DATA_WIDTH  ROM output; holds rom[addr] presented one edge earlier.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  magnitude.
- m_bin  out  ADDR_WIDTH  bin index of m_data.
- m_last  out  1  marks bin NUM_BINS-1.
- peak_mag  out  DATA_WIDTH  largest magnitude seen in the last completed scan.
- peak_bin  out  ADDR_WIDTH  bin of peak_mag.
- peak_valid  out  1  high once a scan completes; cleared by a new start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all outputs 0, FIFO emptied, issue counter 0. Reset mid-scan aborts the scan; no done pulse, peak_valid=0.
- ROM read latency is exactly 1 cycle. A read issued at edge k (rom_addr=A during cycle k-1) yields rom[A] on rom_data during cycle k. A capture pipe flag `rd_pend` records this.
- Output buffer is a 2-entry FIFO holding {data, bin, last}. m_valid is high when the FIFO is non-empty; the head drives m_data, m_bin and m_last.
- Issue rule: a new address is issued in a cycle only if all of the following hold:
  - state=RUN
  - issue_cnt < NUM_BINS
  - FIFO occupancy + rd_pend − (m_valid&&m_ready) < 2
  The FIFO therefore never overflows and rom_data is never dropped.
- Pop and push in the same cycle are legal; occupancy is unchanged.
- State machine:
  - IDLE: start=1 → RUN; clear issue_cnt and peak_mag, set peak_bin=0, peak_valid=0.
  - RUN: issue addresses. When issue_cnt reaches NUM_BINS → DRAIN.
  - DRAIN: no issue; wait until the FIFO is empty and rd_pend=0. The cycle the last word (m_last) handshakes, assert done for 1 cycle, set peak_valid=1 → IDLE.
  - start is ignored outside IDLE.
- rom_addr = issue_cnt[ADDR_WIDTH-1:0]. It holds its last value when not issuing; rereads are harmless.
- Peak update happens on capture into the FIFO: if rom_data > peak_mag (unsigned, strict), load peak_mag and peak_bin. Ties keep the lowest bin. The first captured bin always loads, because peak_mag was cleared to 0 with bin 0 as default.
- peak_mag and peak_bin are stable and meaningful only when peak_valid=1.
- Throughput: 1 word/cycle with m_ready held high. First m_valid appears 2 cycles after start is sampled (IDLE→RUN, issue, capture).
- m_ready low stalls issue within 1 cycle. The FIFO absorbs the in-flight read.
- Width rule: issue_cnt is ADDR_WIDTH+1 bits, so NUM_BINS=2**ADDR_WIDTH needs no wrap.

Decomposition:
- Shared package fft_pkg holds:
  - DATA_WIDTH/ADDR_WIDTH defaults matching the ROM
  - the state enum {IDLE, RUN, DRAIN}
  - the FIFO entry struct {data, bin, last}
- One natural sub-module: fft_skid_fifo2, a 2-entry FIFO with push, pop, count, full and empty. It is reusable on other export paths.
- Counters, issue logic and peak tracking stay in the top module.

Test Plan:
- Use ADDR_WIDTH=4, NUM_BINS=16, with a behavioural ROM model of 1-cycle latency.
- Full-rate scan:
  - Stimulus: ROM=i*3, peak at bin 9 set to 500, m_ready=1.
  - Response: 16 words in 16 consecutive cycles; m_bin 0..15; m_last on bin 15; done 1 cycle after that handshake; peak_mag=500, peak_bin=9, peak_valid=1.
- Backpressure:
  - Stimulus: m_ready toggles 1,0,0,1 repeatedly.
  - Response: no word lost or duplicated; m_data/m_bin stable while m_valid && !m_ready; FIFO count never exceeds 2.
- Tie and edge peaks:
  - ROM all 7 → peak_bin=0.
  - ROM with max 0x3FFFFFF at bins 15 and 3 → peak_bin=3.
  - ROM all 0 → peak_mag=0, peak_bin=0.
- Start handling:
  - start pulses during RUN and DRAIN are ignored; exactly one done pulse.
  - start again after done → peak_valid drops the next cycle, and a full rescan gives identical results.
- Reset mid-scan:
  - Stimulus: rst_n=0 asynchronously at bin 6 with m_ready=0.
  - Response: all outputs 0 immediately, no done pulse; a new start after release scans from bin 0.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared types for the FFT magnitude read-out path: default widths matching the
// magnitude ROM, the scan controller state encoding and the output FIFO entry.
package fft_pkg;
  localparam int FFT_DATA_WIDTH = 26;
  localparam int FFT_ADDR_WIDTH = 13;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  typedef struct packed {
    logic [FFT_DATA_WIDTH-1:0] data;
    logic [FFT_ADDR_WIDTH-1:0] bin;
    logic                      last;
  } fft_entry_t;
endpackage

// File: rtl/fft_skid_fifo2.sv
// Two-entry FIFO for export paths; simultaneous push and pop keep occupancy.
module fft_skid_fifo2
  import fft_pkg::*;
#(
  parameter type T = fft_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  T           din,
  input  logic       pop,
  output T           dout,
  output logic [1:0] count,
  output logic       full,
  output logic       empty
);
  T     mem [2];
  logic wptr, rptr;
  logic do_push, do_pop;

  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (do_pop) rptr <= ~rptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/fft_peak_scan_ctrl.sv
// Scans the FFT magnitude ROM once per start, streams every bin downstream with
// backpressure and records the peak magnitude and its (lowest) bin.
module fft_peak_scan_ctrl
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = FFT_DATA_WIDTH,
  parameter int ADDR_WIDTH = FFT_ADDR_WIDTH,
  parameter int NUM_BINS   = 8192
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [ADDR_WIDTH-1:0] m_bin,
  output logic                  m_last,
  output logic [DATA_WIDTH-1:0] peak_mag,
  output logic [ADDR_WIDTH-1:0] peak_bin,
  output logic                  peak_valid
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] bin;
    logic                  last;
  } entry_t;

  localparam logic [ADDR_WIDTH:0] NBINS    = (ADDR_WIDTH+1)'(NUM_BINS);
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(NUM_BINS - 1);

  state_t                state;
  logic [ADDR_WIDTH:0]   issue_cnt;
  logic                  rd_pend;
  logic [ADDR_WIDTH-1:0] rd_bin;
  logic                  rd_last;
  entry_t                cap, head;
  logic [1:0]            fcount;
  logic                  ffull, fempty;
  logic                  pop, room, issue;

  assign pop      = m_valid && m_ready;
  assign rom_addr = issue_cnt[ADDR_WIDTH-1:0];
  assign m_valid  = !fempty;
  assign m_data   = head.data;
  assign m_bin    = head.bin;
  assign m_last   = head.last;

  // Room for one more read: occupancy + in-flight read - departing word < 2.
  assign room  = ffull ? (pop && !rd_pend) : (fempty || !rd_pend || pop);
  assign issue = (state == RUN) && (issue_cnt < NBINS) && room;

  always_comb begin
    cap      = '0;
    cap.data = rom_data;
    cap.bin  = rd_bin;
    cap.last = rd_last;
  end

  fft_skid_fifo2 #(.T(entry_t)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pend),
    .din   (cap),
    .pop   (pop),
    .dout  (head),
    .count (fcount),
    .full  (ffull),
    .empty (fempty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      issue_cnt  <= '0;
      rd_pend    <= 1'b0;
      rd_bin     <= '0;
      rd_last    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      peak_mag   <= '0;
      peak_bin   <= '0;
      peak_valid <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_pend <= issue;
      if (issue) begin
        issue_cnt <= issue_cnt + 1'b1;
        rd_bin    <= issue_cnt[ADDR_WIDTH-1:0];
        rd_last   <= (issue_cnt == LAST_CNT);
      end
      // Strict compare keeps the lowest bin on ties.
      if (rd_pend && (rom_data > peak_mag)) begin
        peak_mag <= rom_data;
        peak_bin <= rd_bin;
      end
      case (state)
        IDLE: if (start) begin
          state      <= RUN;
          busy       <= 1'b1;
          issue_cnt  <= '0;
          peak_mag   <= '0;
          peak_bin   <= '0;
          peak_valid <= 1'b0;
        end
        RUN: if (issue && (issue_cnt == LAST_CNT)) state <= DRAIN;
        DRAIN: if (pop && head.last) begin
          state      <= IDLE;
          busy       <= 1'b0;
          done       <= 1'b1;
          peak_valid <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
